// File: rtl/tf_key_schedule_if.sv
// Bundle of key/tweak load, subkey stream and status signals for tf_key_schedule.
// master drives key material and load/next; slave is the key schedule itself.
interface tf_key_schedule_if;
  logic [1023:0] key_in;
  logic [191:0]  tweak_in;
  logic          load;
  logic          next;
  logic          busy;
  logic [1023:0] subkey;
  logic [4:0]    subkey_idx;
  logic          subkey_valid;
  logic          done;

  // Handshake: a subkey transfers on a rising edge where subkey_valid and next are both 1;
  // subkey/subkey_idx stay stable while subkey_valid=1 and next=0; next is ignored when subkey_valid=0.
  modport master (
    output key_in, tweak_in, load, next,
    input  busy, subkey, subkey_idx, subkey_valid, done
  );

  modport slave (
    input  key_in, tweak_in, load, next,
    output busy, subkey, subkey_idx, subkey_valid, done
  );
endinterface

// File: rtl/tf_key_schedule.sv
// Threefish-1024 key schedule: captures key and tweak, derives the parity word k16,
// then streams subkeys s = 0..NUM_SUBKEYS-1 under a valid/next handshake.
module tf_key_schedule #(
  parameter int NUM_SUBKEYS = 21
) (
  input  logic                clk,
  input  logic                rst_n,
  tf_key_schedule_if.slave    ks,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PARITY = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [63:0] KS_PARITY = 64'h1BD11BDAA9FC1A22;
  localparam logic [4:0]  LAST_S    = 5'(NUM_SUBKEYS - 1);

  state_t         state_q, state_d;
  logic [1023:0]  key_q, key_d;
  logic [191:0]   tweak_q, tweak_d;
  logic [63:0]    k16_q, k16_d;
  logic [4:0]     s_q, s_d;
  logic [63:0]    parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      tweak_q <= '0;
      k16_q   <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      tweak_q <= tweak_d;
      k16_q   <= k16_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    parity = KS_PARITY;
    for (int i = 0; i < 16; i++) begin
      parity = parity ^ key_q[64*i +: 64];
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    tweak_d = tweak_q;
    k16_d   = k16_q;
    s_d     = s_q;
    case (state_q)
      IDLE: begin
        if (ks.load) begin
          key_d   = ks.key_in;
          tweak_d = ks.tweak_in;
          state_d = PARITY;
        end
      end
      PARITY: begin
        k16_d   = parity;
        s_d     = '0;
        state_d = EMIT;
      end
      EMIT: begin
        // load is deliberately not looked at here: key material is frozen until IDLE.
        if (ks.next) begin
          if (s_q == LAST_S) state_d = DONE;
          else               s_d     = s_q + 5'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subkey words are a rotating window over k0..k16, with tweak/index injected in words 13..15.
  logic [63:0] kw [17];
  logic [63:0] tw [3];
  logic [4:0]  kidx;
  logic [1:0]  t_a_idx, t_b_idx;
  logic [63:0] word;
  logic [1023:0] subkey_c;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      kw[i] = key_q[64*i +: 64];
    end
    kw[16]  = k16_q;
    tw[0]   = tweak_q[63:0];
    tw[1]   = tweak_q[127:64];
    tw[2]   = tweak_q[191:128];
    t_a_idx = 2'(32'(s_q) % 32'd3);
    t_b_idx = 2'((32'(s_q) + 32'd1) % 32'd3);
    kidx    = '0;
    word    = '0;
    subkey_c = '0;
    for (int i = 0; i < 16; i++) begin
      kidx = 5'((32'(s_q) + 32'(i)) % 32'd17);
      word = kw[kidx];
      if (i == 13) word = word + tw[t_a_idx];
      if (i == 14) word = word + tw[t_b_idx];
      if (i == 15) word = word + {59'd0, s_q};
      subkey_c[64*i +: 64] = word;
    end
  end

  assign ks.subkey       = subkey_c;
  assign ks.subkey_idx   = s_q;
  assign ks.subkey_valid = (state_q == EMIT);
  assign ks.busy         = (state_q != IDLE);
  assign ks.done         = (state_q == DONE);
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_tf_key_schedule.sv
// Directed bench for tf_key_schedule: reset values, latency, subkey words for known keys,
// back-to-back acknowledge over a full schedule, load-ignored-in-EMIT and mid-run reset.
module tb_tf_key_schedule;

  localparam logic [63:0]  C  = 64'h1BD11BDAA9FC1A22;
  localparam logic [191:0] TW = {64'hF000000000000014, 64'hF000000000000000, 64'h0000000000000014};

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         n_tests;
  int         n_fail;
  logic [4:0] exp_q[$];
  logic [4:0] exp_s;

  tf_key_schedule_if ks ();

  tf_key_schedule #(.NUM_SUBKEYS(21)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ks        (ks.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] w(input int i);
    return ks.subkey[64*i +: 64];
  endfunction

  // Reference subkey word straight from the Threefish key schedule definition.
  function automatic logic [63:0] ref_word(input logic [1023:0] key, input logic [191:0] tweak,
                                           input int s, input int i);
    logic [63:0] k [17];
    logic [63:0] t [3];
    logic [63:0] r;
    k[16] = C;
    for (int j = 0; j < 16; j++) begin
      k[j]  = key[64*j +: 64];
      k[16] = k[16] ^ k[j];
    end
    t[0] = tweak[63:0];
    t[1] = tweak[127:64];
    t[2] = tweak[191:128];
    r = k[(s + i) % 17];
    if (i == 13) r = r + t[s % 3];
    if (i == 14) r = r + t[(s + 1) % 3];
    if (i == 15) r = r + 64'(s);
    return r;
  endfunction

  task automatic check_status(input string tag, input logic busy, input logic valid, input logic done);
    check({tag, "_busy"},  {63'd0, ks.busy},         {63'd0, busy});
    check({tag, "_valid"}, {63'd0, ks.subkey_valid}, {63'd0, valid});
    check({tag, "_done"},  {63'd0, ks.done},         {63'd0, done});
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    ks.load     = 1'b0;
    ks.next     = 1'b0;
    ks.key_in   = '0;
    ks.tweak_in = '0;
    #2;

    // reset state
    check_status("rst", 1'b0, 1'b0, 1'b0);
    check("rst_idx", {59'd0, ks.subkey_idx}, 64'd0);
    check("rst_subkey_nz", {63'd0, |ks.subkey}, 64'd0);
    check("rst_state", {62'd0, state_dbg}, 64'd0);

    // zero key; load already high when reset releases, so the first edge must take it
    tick();
    ks.tweak_in = TW;
    ks.load     = 1'b1;
    rst_n       = 1'b1;
    tick();
    ks.load = 1'b0;
    check_status("parity", 1'b1, 1'b0, 1'b0);
    tick();
    check_status("s0", 1'b1, 1'b1, 1'b0);
    check("s0_idx", {59'd0, ks.subkey_idx}, 64'd0);
    for (int i = 0; i < 13; i++) check($sformatf("s0_w%0d", i), w(i), 64'd0);
    check("s0_w13", w(13), 64'h0000000000000014);
    check("s0_w14", w(14), 64'hF000000000000000);
    check("s0_w15", w(15), 64'd0);

    // no acknowledge: subkey holds
    tick();
    check("hold_idx", {59'd0, ks.subkey_idx}, 64'd0);
    check("hold_w13", w(13), 64'h0000000000000014);
    check("hold_valid", {63'd0, ks.subkey_valid}, 64'd1);

    ks.next = 1'b1;
    tick();
    ks.next = 1'b0;
    check("s1_idx", {59'd0, ks.subkey_idx}, 64'd1);
    check("s1_w12", w(12), 64'd0);
    check("s1_w13", w(13), 64'hF000000000000000);
    check("s1_w14", w(14), 64'hF000000000000014);
    check("s1_w15", w(15), 64'h1BD11BDAA9FC1A23);

    // next held high to the end; an all-ones load mid-stream must be ignored
    for (int s = 1; s <= 20; s++) exp_q.push_back(5'(s));
    ks.next = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      exp_s = exp_q.pop_front();
      check($sformatf("run_idx_%0d", s), {59'd0, ks.subkey_idx}, {59'd0, exp_s});
      check($sformatf("run_valid_%0d", s), {63'd0, ks.subkey_valid}, 64'd1);
      for (int i = 13; i < 16; i++)
        check($sformatf("run_s%0d_w%0d", s, i), w(i), ref_word('0, TW, s, i));
      check($sformatf("run_s%0d_w0", s), w(0), ref_word('0, TW, s, 0));
      if (s == 5) begin
        ks.load   = 1'b1;
        ks.key_in = '1;
      end else begin
        ks.load = 1'b0;
      end
      tick();
    end
    ks.next = 1'b0;
    check_status("done", 1'b1, 1'b0, 1'b1);
    tick();
    check_status("idle", 1'b0, 1'b0, 1'b0);
    check("idle_state", {62'd0, state_dbg}, 64'd0);

    // all-ones key; next high before valid must not advance s
    ks.key_in = '1;
    ks.load   = 1'b1;
    ks.next   = 1'b1;
    tick();
    ks.load = 1'b0;
    tick();
    check("ones_idx", {59'd0, ks.subkey_idx}, 64'd0);
    check("ones_w0", w(0), 64'hFFFFFFFFFFFFFFFF);
    check("ones_w13", w(13), 64'h0000000000000013);
    check("ones_w15", w(15), 64'hFFFFFFFFFFFFFFFF);
    tick();
    check("ones_s1_idx", {59'd0, ks.subkey_idx}, 64'd1);
    check("ones_k16", w(15), C + 64'd1);

    // reset in the middle of the stream at s=7
    repeat (6) tick();
    ks.next = 1'b0;
    check("pre_rst_idx", {59'd0, ks.subkey_idx}, 64'd7);
    rst_n = 1'b0;
    #1;
    check_status("abort", 1'b0, 1'b0, 1'b0);
    check("abort_idx", {59'd0, ks.subkey_idx}, 64'd0);
    check("abort_subkey_nz", {63'd0, |ks.subkey}, 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("abort_done_%0d", c), {63'd0, ks.done}, 64'd0);
    end

    // restart after reset
    ks.key_in = '0;
    ks.load   = 1'b1;
    rst_n     = 1'b1;
    tick();
    ks.load = 1'b0;
    check("restart_done", {63'd0, ks.done}, 64'd0);
    tick();
    check_status("restart", 1'b1, 1'b1, 1'b0);
    check("restart_idx", {59'd0, ks.subkey_idx}, 64'd0);
    check("restart_w13", w(13), 64'h0000000000000014);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
